// File: rtl/sr04_pkg.sv
// sr04_pkg
// Shared definitions for the SR04 ultrasonic ranger controller: FSM state
// encoding, the echo-time-to-centimetre divisor and the distance width.
// Also provides a saturating increment for the distance counter.
package sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } sr04_state_e;

  // Round-trip sound time per centimetre of distance, in microseconds.
  localparam int CM_DIV = 58;
  localparam int CM_W   = 12;

  localparam logic [CM_W-1:0] CM_MAX   = {CM_W{1'b1}};
  localparam logic [5:0]      SUB_LAST = 6'(CM_DIV - 1);

  // Increment that sticks at full scale instead of wrapping.
  function automatic logic [CM_W-1:0] sat_inc(input logic [CM_W-1:0] v);
    logic [CM_W-1:0] r;
    if (v == CM_MAX) begin
      r = v;
    end else begin
      r = v + {{(CM_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/usec_tick_gen.sv
// usec_tick_gen
// Microsecond prescaler: asserts tick for one cycle every CLK_PER_US clocks.
// Ports:
//   clk     in  system clock
//   reset_n in  synchronous active-low reset
//   clear   in  high in the first cycle of a new FSM state; restarts the period
//   tick    out one-cycle microsecond strobe
// The clear cycle is itself counted as the first clock of the new period, so
// the first tick after a state change lands exactly CLK_PER_US cycles into
// the state.
module usec_tick_gen #(
  parameter int CLK_PER_US = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW     = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] LAST   = CW'(CLK_PER_US - 1);
  localparam logic [CW-1:0] RELOAD = (CLK_PER_US > 1) ? CW'(1) : CW'(0);

  logic [CW-1:0] cnt_r;

  // Period counter, restarted by clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= RELOAD;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Tick decode; a one-clock period ticks even in the clear cycle.
  always_comb begin
    if (clear) begin
      tick = (CLK_PER_US == 1);
    end else begin
      tick = (cnt_r == LAST);
    end
  end

endmodule

// File: rtl/sr04_ranger_ctrl.sv
// sr04_ranger_ctrl
// Controller for an HC-SR04 style ultrasonic ranger. On start it emits a
// trigger pulse, times the echo high width in microseconds and converts it
// to centimetres (one cm per 58 us), with timeouts for a missing echo and an
// over-long echo, followed by a quiet holdoff period.
// Ports:
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   start    in  one-cycle measurement request (ignored while busy)
//   echo     in  asynchronous sensor echo
//   trig     out sensor trigger pulse
//   busy     out high whenever the FSM is not idle
//   cm       out last valid distance in cm
//   cm_valid out one-cycle pulse when cm updates
//   timeout  out one-cycle pulse on a failed measurement
// Build option: define SR04_AUTO_TRIG_EN to re-trigger automatically at the
// end of every holdoff (continuous ranging after the first start).
module sr04_ranger_ctrl
  import sr04_pkg::*;
#(
  parameter int CLK_PER_US   = 100,
  parameter int TRIG_US      = 10,
  parameter int ECHO_WAIT_US = 30000,
  parameter int MAX_ECHO_US  = 25000,
  parameter int HOLDOFF_US   = 60000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            echo,
  output logic            trig,
  output logic            busy,
  output logic [CM_W-1:0] cm,
  output logic            cm_valid,
  output logic            timeout
);

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_US * CLK_PER_US - 1);
  localparam logic [31:0] WAIT_LAST = 32'(ECHO_WAIT_US - 1);
  localparam logic [31:0] MAX_LAST  = 32'(MAX_ECHO_US - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_US - 1);

  sr04_state_e     state_r;
  logic [31:0]     cnt_r;
  logic [5:0]      sub_r;
  logic [CM_W-1:0] work_cm_r;
  logic            clear_r;
  logic            trig_r;
  logic            busy_r;
  logic [CM_W-1:0] cm_r;
  logic            cm_valid_r;
  logic            timeout_r;
  logic            echo_meta_r;
  logic            echo_sync_r;
  logic            echo_prev_r;

  logic            tick_s;
  logic            rise_s;
  logic            fall_s;
  logic            wrap_s;
  logic [CM_W-1:0] work_next_s;

  usec_tick_gen #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear_r),
    .tick   (tick_s)
  );

  // Two-flop echo synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      echo_meta_r <= 1'b0;
      echo_sync_r <= 1'b0;
      echo_prev_r <= 1'b0;
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
      echo_prev_r <= echo_sync_r;
    end
  end

  // Echo edges and the working cm count including this cycle's tick, so a
  // falling edge that coincides with a 58th tick still gets that centimetre.
  always_comb begin
    rise_s = echo_sync_r & ~echo_prev_r;
    fall_s = ~echo_sync_r & echo_prev_r;
    wrap_s = tick_s && (sub_r == SUB_LAST);
    if (wrap_s) begin
      work_next_s = sat_inc(work_cm_r);
    end else begin
      work_next_s = work_cm_r;
    end
  end

  // Measurement FSM with registered outputs. cnt_r counts clocks in TRIG and
  // microsecond ticks elsewhere; clear_r marks the first cycle of each state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 32'd0;
      sub_r      <= 6'd0;
      work_cm_r  <= '0;
      clear_r    <= 1'b0;
      trig_r     <= 1'b0;
      busy_r     <= 1'b0;
      cm_r       <= '0;
      cm_valid_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      cm_valid_r <= 1'b0;
      timeout_r  <= 1'b0;
      clear_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_TRIG;
            trig_r  <= 1'b1;
            busy_r  <= 1'b1;
            cnt_r   <= 32'd0;
            clear_r <= 1'b1;
          end
        end
        ST_TRIG: begin
          if (cnt_r == TRIG_LAST) begin
            state_r <= ST_WAIT_ECHO;
            trig_r  <= 1'b0;
            cnt_r   <= 32'd0;
            clear_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_WAIT_ECHO: begin
          if (rise_s) begin
            state_r   <= ST_MEASURE;
            cnt_r     <= 32'd0;
            sub_r     <= 6'd0;
            work_cm_r <= '0;
            clear_r   <= 1'b1;
          end else if (tick_s) begin
            if (cnt_r == WAIT_LAST) begin
              state_r   <= ST_HOLDOFF;
              timeout_r <= 1'b1;
              cnt_r     <= 32'd0;
              clear_r   <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 32'd1;
            end
          end
        end
        ST_MEASURE: begin
          // A falling edge wins over a simultaneous max-width timeout, so
          // cm_valid and timeout can never pulse together.
          if (fall_s) begin
            state_r    <= ST_HOLDOFF;
            cm_r       <= work_next_s;
            cm_valid_r <= 1'b1;
            cnt_r      <= 32'd0;
            clear_r    <= 1'b1;
          end else if (tick_s) begin
            work_cm_r <= work_next_s;
            sub_r     <= wrap_s ? 6'd0 : sub_r + 6'd1;
            if (cnt_r == MAX_LAST) begin
              state_r   <= ST_HOLDOFF;
              timeout_r <= 1'b1;
              cnt_r     <= 32'd0;
              clear_r   <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 32'd1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (tick_s) begin
            if (cnt_r == HOLD_LAST) begin
`ifdef SR04_AUTO_TRIG_EN
              state_r <= ST_TRIG;
              trig_r  <= 1'b1;
`else
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
`endif
              cnt_r   <= 32'd0;
              clear_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 32'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          trig_r  <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= 32'd0;
          clear_r <= 1'b1;
        end
      endcase
    end
  end

  assign trig     = trig_r;
  assign busy     = busy_r;
  assign cm       = cm_r;
  assign cm_valid = cm_valid_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_sr04_ranger_ctrl.sv
// tb_sr04_ranger_ctrl
// Directed plus randomized bench for sr04_ranger_ctrl with scaled-down
// timing parameters. Expected distances and event times are computed from
// the behavioural rules: cm = min(width_us / 58, 4095), 3-cycle echo edge
// latency, and state durations of parameter * CLK_PER_US clocks.
module tb_sr04_ranger_ctrl;

  localparam int CPU      = 2;
  localparam int TUS      = 10;
  localparam int EW       = 300;
  localparam int MX       = 2500;
  localparam int HO       = 100;
  localparam int TRIG_CYC = TUS * CPU;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        echo    = 1'b0;
  logic        trig;
  logic        busy;
  logic [11:0] cm;
  logic        cm_valid;
  logic        timeout;

  int cyc      = 0;
  int n_trig   = 0;
  int n_cmv    = 0;
  int n_to     = 0;
  int n_both   = 0;
  int to_cyc   = 0;
  logic trig_q = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_cm   = 0;

  always #5 clk = ~clk;

  sr04_ranger_ctrl #(
    .CLK_PER_US  (CPU),
    .TRIG_US     (TUS),
    .ECHO_WAIT_US(EW),
    .MAX_ECHO_US (MX),
    .HOLDOFF_US  (HO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .echo    (echo),
    .trig    (trig),
    .busy    (busy),
    .cm      (cm),
    .cm_valid(cm_valid),
    .timeout (timeout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pulse cycles and stamps timeouts.
  always @(negedge clk) begin
    trig_q <= trig;
    if (trig === 1'b1 && trig_q !== 1'b1) n_trig <= n_trig + 1;
    if (cm_valid === 1'b1) n_cmv <= n_cmv + 1;
    if (timeout === 1'b1) begin
      n_to   <= n_to + 1;
      to_cyc <= cyc;
    end
    if (cm_valid === 1'b1 && timeout === 1'b1) n_both <= n_both + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel_sig(input int s);
    case (s)
      0: return trig;
      1: return busy;
      2: return cm_valid;
      default: return timeout;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int s, input logic v, input int lim,
                          output int at);
    int n = 0;
    while (sel_sig(s) !== v && n < lim) begin
      step();
      n++;
    end
    at = cyc;
    chk({tag, "_seen"}, {31'd0, sel_sig(s)}, {31'd0, v});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    exp_cm  = 0;
    step();
  endtask

  // One measurement. delay_us < 0 means the echo never rises.
  task automatic run_meas(input int delay_us, input int width_us, input bit poke);
    int t0, t1, k, fc, h, t, tr0, cmv0, to0, e;
    tr0  = n_trig;
    cmv0 = n_cmv;
    to0  = n_to;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("trig_on", {31'd0, trig}, 32'd1);
    t0 = cyc;
    wait_for("trig_off", 0, 1'b0, TRIG_CYC + 5, t1);
    chk("trig_width", t1 - t0, TRIG_CYC);
    if (delay_us < 0) begin
      wait_for("wait_to", 3, 1'b1, EW * CPU + 10, h);
      chk("wait_to_time", h - t1, EW * CPU);
      chk("wait_to_no_cmv", n_cmv - cmv0, 0);
    end else begin
      repeat (delay_us * CPU) step();
      echo = 1'b1;
      k = cyc;
      for (int i = 0; i < width_us * CPU; i++) begin
        start = poke && (i == 10);
        step();
      end
      start = 1'b0;
      echo  = 1'b0;
      fc = cyc;
      if (width_us >= MX) begin
        chk("meas_to_cnt", n_to - to0, 1);
        chk("meas_to_time", to_cyc - k, 3 + MX * CPU);
        chk("meas_to_no_cmv", n_cmv - cmv0, 0);
        h = to_cyc;
      end else begin
        wait_for("cmv", 2, 1'b1, 10, h);
        chk("cmv_latency", h - fc, 3);
        e = width_us / 58;
        if (e > 4095) e = 4095;
        exp_cm = e;
        chk("meas_no_to", n_to - to0, 0);
      end
    end
    chk("cm_value", {20'd0, cm}, exp_cm);
    if (poke) begin
      repeat (5) step();
      start = 1'b1;
      echo  = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      echo = 1'b0;
    end
    chk("single_trig", n_trig - tr0, 1);
`ifdef SR04_AUTO_TRIG_EN
    wait_for("auto_retrig", 0, 1'b1, HO * CPU + 20, t);
    chk("holdoff_len", t - h, HO * CPU);
    chk("pulse_cnt", (n_cmv - cmv0) + (n_to - to0), 1);
    do_reset();
`else
    wait_for("idle", 1, 1'b0, HO * CPU + 20, t);
    chk("holdoff_len", t - h, HO * CPU);
    chk("pulse_cnt", (n_cmv - cmv0) + (n_to - to0), 1);
`endif
    chk("cm_hold", {20'd0, cm}, exp_cm);
  endtask

  initial begin
    int cmv0, to0, tr0, d, w;
    step();
    step();
    step();
    chk("rst_trig", {31'd0, trig}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cm", {20'd0, cm}, 32'd0);
    chk("rst_cm_valid", {31'd0, cm_valid}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    reset_n = 1'b1;
    step();

    run_meas(200, 580, 1'b1);
    run_meas(10, 57, 1'b0);
    run_meas(10, 58, 1'b0);
    run_meas(50, 1160, 1'b0);
    run_meas(-1, 0, 1'b0);
    run_meas(20, 2550, 1'b0);

    // Give cm a nonzero value, then reset in the middle of TRIG.
    run_meas(5, 700, 1'b0);
    cmv0 = n_cmv;
    to0  = n_to;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("trig_before_rst", {31'd0, trig}, 32'd1);
    reset_n = 1'b0;
    step();
    chk("midrst_trig", {31'd0, trig}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cm", {20'd0, cm}, 32'd0);
    reset_n = 1'b1;
    exp_cm = 0;
    repeat (800) step();
    chk("midrst_no_cmv", n_cmv - cmv0, 0);
    chk("midrst_no_to", n_to - to0, 0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);

    for (int r = 0; r < 6; r++) begin
      d = int'($urandom_range(0, 250));
      w = int'($urandom_range(1, 1800));
      run_meas(d, w, 1'b0);
    end

`ifndef SR04_AUTO_TRIG_EN
    tr0 = n_trig;
    repeat (300) step();
    chk("no_auto_trig", n_trig - tr0, 0);
    chk("end_idle", {31'd0, busy}, 32'd0);
`endif
    chk("no_both_pulses", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr04_ranger_ctrl.md
SR04_RANGER_CTRL -- requirements
Module: sr04_ranger_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 100, system clocks per microsecond.
REQ-002 SHALL have parameter TRIG_US, default 10, trigger pulse width in us.
REQ-003 SHALL have parameter ECHO_WAIT_US, default 30000, maximum wait from trigger end to echo rise.
REQ-004 SHALL have parameter MAX_ECHO_US, default 25000, maximum accepted echo high width.
REQ-005 SHALL have parameter HOLDOFF_US, default 60000, quiet time after each measurement.
REQ-006 SHALL have one clock and a synchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1, system clock; all logic on posedge.
REQ-008 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port start, input, 1, one-cycle measurement request.
REQ-010 SHALL have port echo, input, 1, asynchronous sensor echo.
REQ-011 SHALL have port trig, output, 1, sensor trigger pulse.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port cm, output, 12, last valid distance in cm.
REQ-014 SHALL have port cm_valid, output, 1, one-cycle pulse when cm updates.
REQ-015 SHALL have port timeout, output, 1, one-cycle pulse on failed measurement.

Function
REQ-016 SHALL pass echo through a 2-flop synchronizer; edges are detected on the synchronized signal, giving 3-cycle worst-case edge latency.
REQ-017 SHALL generate a us tick every CLK_PER_US clocks; the prescaler clears on every state change so each state's duration is exact.
REQ-018 SHALL implement states IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-019 In IDLE, start SHALL move to TRIG on the next edge; trig is asserted in the first TRIG cycle.
REQ-020 TRIG SHALL hold trig high for exactly TRIG_US*CLK_PER_US cycles, then enter WAIT_ECHO with trig low.
REQ-021 In WAIT_ECHO, an echo rising edge SHALL enter MEASURE; ECHO_WAIT_US ticks without a rising edge SHALL pulse timeout and enter HOLDOFF.
REQ-022 MEASURE SHALL count ticks with a 0..57 sub-counter; each wrap from 57 to 0 increments a working cm count, which saturates at 4095.
REQ-023 An echo falling edge in MEASURE SHALL load cm with the working count, pulse cm_valid in the same cycle, and enter HOLDOFF.
REQ-024 If MEASURE reaches MAX_ECHO_US ticks, the block SHALL pulse timeout, leave cm unchanged, and enter HOLDOFF.
REQ-025 HOLDOFF SHALL last HOLDOFF_US ticks, then return to IDLE; echo is ignored in HOLDOFF.
REQ-026 start SHALL be ignored while busy and is not queued.
REQ-027 cm_valid and timeout SHALL never assert in the same cycle.

Reset
REQ-028 While reset_n=0 at a clock edge, the next state SHALL be IDLE, with trig=0, busy=0, cm=0, cm_valid=0, timeout=0, and all counters and synchronizer flops 0.
REQ-029 Reset asserted mid-operation SHALL drop trig at that edge; no cm_valid or timeout pulse is emitted for the aborted measurement.

Configuration
REQ-030 Macro SR04_AUTO_TRIG_EN SHALL control automatic triggering.
REQ-031 With SR04_AUTO_TRIG_EN defined, the exit from HOLDOFF SHALL go directly to TRIG, giving continuous measurement; start is still accepted in IDLE after reset.
REQ-032 With SR04_AUTO_TRIG_EN undefined, the exit from HOLDOFF SHALL go to IDLE, and each measurement requires start.

Structure
REQ-033 Shared package sr04_pkg SHALL hold the state encoding, the divisor constant 58, and the cm width (12).
REQ-034 The us prescaler SHALL be a separate sub-module, usec_tick_gen, with inputs clk, reset_n and clear, and output tick.

Verification
REQ-035 Scenario: start; echo high for 580 us after 200 us -> trig high for 1000 cycles, cm=10, one cm_valid pulse, busy high until HOLDOFF ends.
REQ-036 Scenario: echo high for 1160 us -> cm=20; then echo high for 57 us -> cm=0 with cm_valid.
REQ-037 Scenario: start with echo held low -> timeout pulse exactly 30000 us after trig falls, cm unchanged.
REQ-038 Scenario: echo held high for 26000 us -> timeout at 25000 us into MEASURE, no cm_valid.
REQ-039 Scenario: start pulsed during MEASURE and HOLDOFF -> no extra trig; reset_n=0 during TRIG -> trig low next edge, outputs 0.
REQ-040 Scenario: with SR04_AUTO_TRIG_EN and one start -> trig repeats every measurement cycle with no further start; without it -> a single trig only.
